// File: rtl/tremolo_demod_if.sv
// Sample-bus bundle for the tremolo demodulator: control and audio in,
// envelope/period/depth readback out.
interface tremolo_demod_if #(
   parameter int unsigned PERIOD_W = 20
);
   logic                en;
   logic                in_valid;
   logic signed [15:0]  audio_in;
   logic [15:0]         hi_thr;
   logic [15:0]         lo_thr;
   logic [15:0]         env_out;
   logic                env_valid;
   logic [PERIOD_W-1:0] period_out;
   logic [15:0]         depth_out;
   logic                period_valid;

   modport master (
      output en, in_valid, audio_in, hi_thr, lo_thr,
      input  env_out, env_valid, period_out, depth_out, period_valid
   );

   modport slave (
      input  en, in_valid, audio_in, hi_thr, lo_thr,
      output env_out, env_valid, period_out, depth_out, period_valid
   );
endinterface

// File: rtl/tremolo_demod.sv
// Tremolo demodulator: follows an attack/release envelope of the sample stream
// and measures modulation period and depth between successive rising edges.
module tremolo_demod #(
   parameter int unsigned ATTACK_SH  = 2,
   parameter int unsigned RELEASE_SH = 6,
   parameter int unsigned PERIOD_W   = 20,
   parameter int unsigned MAX_PERIOD = 480000
) (
   input  logic            clk,
   input  logic            rst,
   tremolo_demod_if.slave  bus
);
   localparam int unsigned SW = 16;
   localparam int unsigned EW = 17;
   localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(MAX_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SW-1:0]       env_q, env_d;
   logic [SW-1:0]       max_q, max_d;
   logic [SW-1:0]       min_q, min_d;
   logic [SW-1:0]       depth_q, depth_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                env_valid_q, env_valid_d;
   logic                period_valid_q, period_valid_d;

   logic [SW-1:0]       raw_c, abs_c, lo_eff_c, env_new_c;
   logic [EW-1:0]       a_ext_c, e_ext_c, diff_c, step_c, sum_c;

   // Magnitude with -32768 clamped, then one envelope step toward it
   always_comb begin
      raw_c = bus.audio_in;
      if (raw_c[SW-1]) begin
         abs_c = (raw_c[SW-2:0] == '0) ? 16'h7FFF : SW'(~raw_c + 16'd1);
      end else begin
         abs_c = raw_c;
      end
      a_ext_c = {1'b0, abs_c};
      e_ext_c = {1'b0, env_q};
      diff_c  = '0;
      step_c  = '0;
      sum_c   = e_ext_c;
      if (a_ext_c > e_ext_c) begin
         diff_c = a_ext_c - e_ext_c;
         step_c = diff_c >> ATTACK_SH;
         if (step_c == '0) step_c = EW'(1);
         sum_c  = e_ext_c + step_c;
      end else if (a_ext_c < e_ext_c) begin
         diff_c = e_ext_c - a_ext_c;
         step_c = diff_c >> RELEASE_SH;
         if (step_c == '0) step_c = EW'(1);
         sum_c  = e_ext_c - step_c;
      end
      env_new_c = SW'(sum_c);
      lo_eff_c  = (bus.lo_thr < bus.hi_thr) ? bus.lo_thr : bus.hi_thr;
   end

   always_comb begin
      state_d        = state_q;
      env_d          = env_q;
      max_d          = max_q;
      min_d          = min_q;
      depth_d        = depth_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      env_valid_d    = 1'b0;
      period_valid_d = 1'b0;

      if (!bus.en) begin
         state_d  = S_IDLE;
         env_d    = '0;
         max_d    = '0;
         min_d    = '0;
         depth_d  = '0;
         cnt_d    = '0;
         period_d = '0;
      end else if (bus.in_valid) begin
         env_d       = env_new_c;
         env_valid_d = 1'b1;

         unique case (state_q)
            S_IDLE: begin
               if (env_new_c >= bus.hi_thr)     state_d = S_HIGH;
               else if (env_new_c < lo_eff_c)   state_d = S_LOW;
            end
            S_HIGH: if (env_new_c < lo_eff_c)   state_d = S_LOW;
            S_LOW:  if (env_new_c >= bus.hi_thr) state_d = S_HIGH;
            default: state_d = S_IDLE;
         endcase

         // Rising edge closes the running cycle (if armed) and opens a new one
         if ((state_d == S_HIGH) && (state_q != S_HIGH)) begin
            if ((state_q == S_LOW) && (cnt_q != '0)) begin
               period_d       = cnt_q;
               depth_d        = max_q - min_q;
               period_valid_d = 1'b1;
            end
            cnt_d = PERIOD_W'(1);
            max_d = env_new_c;
            min_d = env_new_c;
         end else if ((state_q != S_IDLE) && (cnt_q != '0)) begin
            if (cnt_q >= CNT_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + PERIOD_W'(1);
               if (env_new_c > max_q) max_d = env_new_c;
               if (env_new_c < min_q) min_d = env_new_c;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         env_q          <= '0;
         max_q          <= '0;
         min_q          <= '0;
         depth_q        <= '0;
         cnt_q          <= '0;
         period_q       <= '0;
         env_valid_q    <= 1'b0;
         period_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         env_q          <= env_d;
         max_q          <= max_d;
         min_q          <= min_d;
         depth_q        <= depth_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         env_valid_q    <= env_valid_d;
         period_valid_q <= period_valid_d;
      end
   end

   assign bus.env_out      = env_q;
   assign bus.env_valid    = env_valid_q;
   assign bus.period_out   = period_q;
   assign bus.depth_out    = depth_q;
   assign bus.period_valid = period_valid_q;

endmodule

// File: tb/tb_tremolo_demod.sv
// Directed bench for tremolo_demod: one slow-envelope instance for step math,
// one instant-envelope instance for saturation, period/depth and timeout.
module tb_tremolo_demod;
   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   pulses_b;
   int   first_b;
   int   n_b;
   logic [31:0] per_min, per_max, dep_min, dep_max;

   tremolo_demod_if #(.PERIOD_W(20)) if_a ();
   tremolo_demod_if #(.PERIOD_W(20)) if_b ();

   tremolo_demod #(.ATTACK_SH(2), .RELEASE_SH(6), .PERIOD_W(20), .MAX_PERIOD(480000))
      u_a (.clk(clk), .rst(rst), .bus(if_a));

   tremolo_demod #(.ATTACK_SH(0), .RELEASE_SH(0), .PERIOD_W(20), .MAX_PERIOD(1000))
      u_b (.clk(clk), .rst(rst), .bus(if_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [15:0] s);
      if_a.in_valid = 1'b1;
      if_a.audio_in = s;
      cyc();
   endtask

   task automatic send_b(input logic [15:0] s);
      if_b.in_valid = 1'b1;
      if_b.audio_in = s;
      cyc();
      n_b++;
      if (if_b.period_valid === 1'b1) begin
         pulses_b++;
         if (first_b == 0) first_b = n_b;
         if (32'(if_b.period_out) < per_min) per_min = 32'(if_b.period_out);
         if (32'(if_b.period_out) > per_max) per_max = 32'(if_b.period_out);
         if (32'(if_b.depth_out)  < dep_min) dep_min = 32'(if_b.depth_out);
         if (32'(if_b.depth_out)  > dep_max) dep_max = 32'(if_b.depth_out);
      end
   endtask

   task automatic clr_b();
      pulses_b = 0;
      first_b  = 0;
      n_b      = 0;
      per_min  = '1;
      per_max  = '0;
      dep_min  = '1;
      dep_max  = '0;
   endtask

   // nper full periods of 64 loud / 64 silent samples, then one loud sample
   task automatic run_square(input int nper);
      for (int p = 0; p < nper; p++) begin
         for (int i = 0; i < 64; i++) send_b(16'd20000);
         for (int i = 0; i < 64; i++) send_b(16'd0);
      end
      send_b(16'd20000);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clr_b();
      rst = 1'b1;
      if_a.en = 1'b1; if_a.in_valid = 1'b0; if_a.audio_in = 16'sd20000;
      if_a.hi_thr = 16'd30000; if_a.lo_thr = 16'd20000;
      if_b.en = 1'b1; if_b.in_valid = 1'b0; if_b.audio_in = 16'sd20000;
      if_b.hi_thr = 16'd8000; if_b.lo_thr = 16'd4000;

      for (int i = 0; i < 2; i++) begin
         if_a.in_valid = (i == 0);
         if_b.in_valid = (i == 0);
         cyc();
      end
      chk("rst_env_a",    32'(if_a.env_out), 32'd0);
      chk("rst_envv_a",   32'(if_a.env_valid), 32'd0);
      chk("rst_pv_a",     32'(if_a.period_valid), 32'd0);
      chk("rst_depth_a",  32'(if_a.depth_out), 32'd0);
      chk("rst_env_b",    32'(if_b.env_out), 32'd0);
      rst = 1'b0;
      if_a.in_valid = 1'b0;
      if_b.in_valid = 1'b0;
      cyc();

      // Attack/release step arithmetic on the slow instance
      send_a(16'hFC18);                       // -1000
      chk("abs_attack1",  32'(if_a.env_out), 32'd250);
      chk("envv_pulse",   32'(if_a.env_valid), 32'd1);
      send_a(16'hFC18);
      chk("attack2",      32'(if_a.env_out), 32'd437);
      send_a(16'd0);
      chk("release",      32'(if_a.env_out), 32'd431);
      send_a(16'd431);
      chk("equal_hold",   32'(if_a.env_out), 32'd431);
      chk("equal_envv",   32'(if_a.env_valid), 32'd1);
      if_a.in_valid = 1'b0;
      cyc();
      chk("idle_env",     32'(if_a.env_out), 32'd431);
      chk("idle_envv",    32'(if_a.env_valid), 32'd0);
      if_a.en = 1'b0; if_a.in_valid = 1'b1; if_a.audio_in = 16'sd1000;
      cyc();
      chk("en_off_env",   32'(if_a.env_out), 32'd0);
      chk("en_off_envv",  32'(if_a.env_valid), 32'd0);
      if_a.en = 1'b1;
      send_a(16'd400);
      chk("to_100",       32'(if_a.env_out), 32'd100);
      send_a(16'd99);
      chk("min_rel_step", 32'(if_a.env_out), 32'd99);
      send_a(16'd100);
      chk("min_att_step", 32'(if_a.env_out), 32'd100);
      send_a(16'h8000);
      chk("sat_attack2",  32'(if_a.env_out), 32'd8266);
      if_a.in_valid = 1'b0;

      // Saturation with immediate attack
      send_b(16'h8000);
      chk("sat_env",      32'(if_b.env_out), 32'd32767);
      chk("sat_envv",     32'(if_b.env_valid), 32'd1);
      chk("sat_nopv",     32'(if_b.period_valid), 32'd0);
      if_b.in_valid = 1'b0;
      cyc();
      chk("sat_envv_end", 32'(if_b.env_valid), 32'd0);
      chk("sat_env_hold", 32'(if_b.env_out), 32'd32767);
      if_b.en = 1'b0;
      cyc();
      chk("clr_env_b",    32'(if_b.env_out), 32'd0);
      if_b.en = 1'b1;

      // Square modulation: arm on first rise, measure on later rises
      clr_b();
      run_square(3);
      chk("sq_pulses",    32'(pulses_b), 32'd3);
      chk("sq_first",     32'(first_b), 32'd129);
      chk("sq_per_min",   per_min, 32'd128);
      chk("sq_per_max",   per_max, 32'd128);
      chk("sq_dep_min",   dep_min, 32'd20000);
      chk("sq_dep_max",   dep_max, 32'd20000);
      if_b.in_valid = 1'b0;
      cyc();
      chk("sq_pv_end",    32'(if_b.period_valid), 32'd0);
      chk("sq_per_hold",  32'(if_b.period_out), 32'd128);
      chk("sq_dep_hold",  32'(if_b.depth_out), 32'd20000);

      // Enable dropped mid-cycle, then restored
      for (int i = 0; i < 10; i++) send_b(16'd20000);
      if_b.en = 1'b0;
      cyc();
      chk("drop_env",     32'(if_b.env_out), 32'd0);
      chk("drop_per",     32'(if_b.period_out), 32'd0);
      if_b.en = 1'b1;
      clr_b();
      run_square(2);
      chk("rest_pulses",  32'(pulses_b), 32'd2);
      chk("rest_first",   32'(first_b), 32'd129);
      chk("rest_per",     per_max, 32'd128);

      // Timeout at 1000 samples, then re-arm and a short measured cycle
      if_b.in_valid = 1'b0;
      if_b.en = 1'b0;
      cyc();
      if_b.en = 1'b1;
      clr_b();
      for (int i = 0; i < 1200; i++) send_b(16'd20000);
      chk("to_nopulse",   32'(pulses_b), 32'd0);
      send_b(16'd0);
      send_b(16'd20000);
      chk("to_pulses",    32'(pulses_b), 32'd1);
      chk("to_period",    per_min, 32'd201);
      chk("to_depth",     dep_min, 32'd20000);
      if_b.in_valid = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
